// File: rtl/mem_stage.sv
// Memory-access stage: forms load/store requests for the data port, holds them
// until the response, stalls the pipeline meanwhile and latches late read data.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_res,
    input  logic [31:0] rs2_data,
    input  logic        advance,
    output logic [31:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [31:0] mem_rdata,
    output logic [1:0]  bit_shift,
    output logic [3:0]  wmask_out,
    output logic [3:0]  rmask_out,
    output logic [31:0] write_data,
    output logic        trap,
    output logic        mem_stall
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [31:0] rdata_hold;
    logic [3:0]  base_mask;
    logic [3:0]  mask;
    logic        access;
    logic        op;
    logic        req_phase;

    // Sign of the load is applied in writeback; only the width matters here.
    logic        unused_sign;
    assign unused_sign = funct3[2];

    always_comb begin
        base_mask = 4'b0000;
        case (funct3[1:0])
            2'b00:   base_mask = 4'b0001;
            2'b01:   base_mask = 4'b0011;
            2'b10:   base_mask = 4'b1111;
            default: base_mask = 4'b0000;
        endcase
    end

    assign mask   = 4'(base_mask << alu_res[1:0]);
    assign access = valid & (mem_read | mem_write);
    assign trap   = access & (((funct3[1:0] == 2'b01) & alu_res[0]) |
                              ((funct3[1:0] == 2'b10) & (alu_res[1:0] != 2'b00)));
    assign op     = access & ~trap;

    assign dmem_address = {alu_res[31:2], 2'b00};
    assign bit_shift    = alu_res[1:0];
    assign rmask_out    = (mem_read  & ~trap) ? mask : 4'b0000;
    assign wmask_out    = (mem_write & ~trap) ? mask : 4'b0000;
    assign dmem_wmask   = wmask_out;
    assign write_data   = rs2_data << {alu_res[1:0], 3'b000};
    assign dmem_wdata   = write_data;

    // Request stays up from issue until the response; never reissued from DONE.
    assign req_phase  = ((state == IDLE) & op) | (state == BUSY);
    assign dmem_read  = ~rst & mem_read  & req_phase;
    assign dmem_write = ~rst & mem_write & req_phase;
    assign mem_stall  = ~rst & req_phase & ~dmem_resp;

    assign mem_rdata  = (state == DONE) ? rdata_hold : dmem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rdata_hold <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (op & dmem_resp & ~advance) begin
                        state      <= DONE;
                        rdata_hold <= dmem_rdata;
                    end else if (op & ~dmem_resp) begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (dmem_resp) begin
                        if (advance) begin
                            state <= IDLE;
                        end else begin
                            state      <= DONE;
                            rdata_hold <= dmem_rdata;
                        end
                    end
                end
                DONE: begin
                    if (advance) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: loads, stores, traps, held responses,
// back-to-back zero-wait accesses and reset during an outstanding request.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_res;
    logic [31:0] rs2_data;
    logic        advance;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] mem_rdata;
    logic [1:0]  bit_shift;
    logic [3:0]  wmask_out;
    logic [3:0]  rmask_out;
    logic [31:0] write_data;
    logic        trap;
    logic        mem_stall;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage dut (
        .clk(clk), .rst(rst), .valid(valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .alu_res(alu_res),
        .rs2_data(rs2_data), .advance(advance), .dmem_address(dmem_address),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .mem_rdata(mem_rdata), .bit_shift(bit_shift), .wmask_out(wmask_out),
        .rmask_out(rmask_out), .write_data(write_data), .trap(trap),
        .mem_stall(mem_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_op(input logic v, input logic r, input logic w,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data);
        valid = v; mem_read = r; mem_write = w;
        funct3 = f3; alu_res = addr; rs2_data = data;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        dmem_resp = 1'b0; dmem_rdata = 32'h1234_5678; advance = 1'b0;
        @(negedge clk);
        n_cmp++; if (dmem_read !== 1'b0) begin n_err++; $display("FAIL reset_dmem_read: got %b want 0", dmem_read); end
        n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL reset_mem_stall: got %b want 0", mem_stall); end
        n_cmp++; if (dmem_address !== 32'h0000_0100) begin n_err++; $display("FAIL reset_address: got %h want 00000100", dmem_address); end
        n_cmp++; if (rmask_out !== 4'b1111) begin n_err++; $display("FAIL reset_rmask: got %b want 1111", rmask_out); end
        n_cmp++; if (mem_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL reset_mem_rdata: got %h want 12345678", mem_rdata); end
        next_cycle();
        rst = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL idle_mem_stall: got %b want 0", mem_stall); end
        n_cmp++; if (dmem_read !== 1'b0) begin n_err++; $display("FAIL idle_dmem_read: got %b want 0", dmem_read); end
        next_cycle();
    endtask

    // lw at 0x100 with a memory that answers two cycles after the request.
    task automatic test_load_word();
        int rd_cnt = 0;
        int st_cnt = 0;
        set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        for (int i = 0; i < 3; i++) begin
            dmem_resp  = (i == 2);
            advance    = (i == 2);
            dmem_rdata = (i == 2) ? 32'hCAFE_F00D : 32'h0;
            @(negedge clk);
            if (dmem_read) rd_cnt++;
            if (mem_stall) st_cnt++;
            if (i == 2) begin
                n_cmp++; if (mem_rdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL lw_mem_rdata: got %h want cafef00d", mem_rdata); end
                n_cmp++; if (rmask_out !== 4'b1111) begin n_err++; $display("FAIL lw_rmask: got %b want 1111", rmask_out); end
                n_cmp++; if (dmem_address !== 32'h0000_0100) begin n_err++; $display("FAIL lw_address: got %h want 00000100", dmem_address); end
            end
            next_cycle();
        end
        n_cmp++; if (rd_cnt != 3) begin n_err++; $display("FAIL lw_read_cycles: got %0d want 3", rd_cnt); end
        n_cmp++; if (st_cnt != 2) begin n_err++; $display("FAIL lw_stall_cycles: got %0d want 2", st_cnt); end
        set_op(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        dmem_resp = 1'b0;
        @(negedge clk);
        n_cmp++; if (dmem_read !== 1'b0) begin n_err++; $display("FAIL lw_back_idle: got dmem_read %b want 0", dmem_read); end
        next_cycle();
    endtask

    task automatic test_store_byte();
        set_op(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB);
        dmem_resp = 1'b1; advance = 1'b1;
        @(negedge clk);
        n_cmp++; if (dmem_address !== 32'h0000_0100) begin n_err++; $display("FAIL sb_address: got %h want 00000100", dmem_address); end
        n_cmp++; if (dmem_wmask !== 4'b1000) begin n_err++; $display("FAIL sb_dmem_wmask: got %b want 1000", dmem_wmask); end
        n_cmp++; if (wmask_out !== 4'b1000) begin n_err++; $display("FAIL sb_wmask_out: got %b want 1000", wmask_out); end
        n_cmp++; if (dmem_wdata !== 32'hAB00_0000) begin n_err++; $display("FAIL sb_wdata: got %h want ab000000", dmem_wdata); end
        n_cmp++; if (write_data !== 32'hAB00_0000) begin n_err++; $display("FAIL sb_write_data: got %h want ab000000", write_data); end
        n_cmp++; if (rmask_out !== 4'b0000) begin n_err++; $display("FAIL sb_rmask: got %b want 0000", rmask_out); end
        n_cmp++; if (dmem_write !== 1'b1) begin n_err++; $display("FAIL sb_dmem_write: got %b want 1", dmem_write); end
        n_cmp++; if (bit_shift !== 2'd3) begin n_err++; $display("FAIL sb_bit_shift: got %0d want 3", bit_shift); end
        n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL sb_stall: got %b want 0", mem_stall); end
        next_cycle();
        // Half unsigned at offset 2 is aligned: mask 1100, data shifted by 16.
        set_op(1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0000_BEEF);
        @(negedge clk);
        n_cmp++; if (trap !== 1'b0) begin n_err++; $display("FAIL lhu_trap: got %b want 0", trap); end
        n_cmp++; if (rmask_out !== 4'b1100) begin n_err++; $display("FAIL lhu_rmask: got %b want 1100", rmask_out); end
        n_cmp++; if (write_data !== 32'hBEEF_0000) begin n_err++; $display("FAIL lhu_write_data: got %h want beef0000", write_data); end
        next_cycle();
        // funct3 x11 has no valid width: zero mask, no trap.
        set_op(1'b1, 1'b1, 1'b0, 3'b011, 32'h0000_0203, 32'h0);
        @(negedge clk);
        n_cmp++; if (trap !== 1'b0) begin n_err++; $display("FAIL f3_11_trap: got %b want 0", trap); end
        n_cmp++; if (rmask_out !== 4'b0000) begin n_err++; $display("FAIL f3_11_rmask: got %b want 0000", rmask_out); end
        next_cycle();
    endtask

    task automatic test_misaligned();
        logic [31:0] addr_tab [3];
        logic [2:0]  f3_tab   [3];
        logic        wr_tab   [3];
        addr_tab[0] = 32'h0000_0101; f3_tab[0] = 3'b001; wr_tab[0] = 1'b0;
        addr_tab[1] = 32'h0000_0102; f3_tab[1] = 3'b010; wr_tab[1] = 1'b0;
        addr_tab[2] = 32'h0000_0103; f3_tab[2] = 3'b001; wr_tab[2] = 1'b1;
        dmem_resp = 1'b0; advance = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(1'b1, ~wr_tab[i], wr_tab[i], f3_tab[i], addr_tab[i], 32'h1111_2222);
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                n_cmp++; if (trap !== 1'b1) begin n_err++; $display("FAIL mis%0d_trap: got %b want 1", i, trap); end
                n_cmp++; if ({dmem_read, dmem_write} !== 2'b00) begin n_err++; $display("FAIL mis%0d_request: got %b want 00", i, {dmem_read, dmem_write}); end
                n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL mis%0d_stall: got %b want 0", i, mem_stall); end
                n_cmp++; if ({rmask_out, wmask_out, dmem_wmask} !== 12'h000) begin n_err++; $display("FAIL mis%0d_masks: got %h want 000", i, {rmask_out, wmask_out, dmem_wmask}); end
                next_cycle();
            end
        end
        set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        advance = 1'b1;
        next_cycle();
    endtask

    task automatic test_resp_held();
        // Zero-wait response while held: IDLE -> DONE.
        set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0);
        dmem_resp = 1'b1; dmem_rdata = 32'hDEAD_BEEF; advance = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL held_first: got %h want deadbeef", mem_rdata); end
        n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL held_first_stall: got %b want 0", mem_stall); end
        next_cycle();
        dmem_resp = 1'b0; dmem_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            advance = (i == 3);
            @(negedge clk);
            n_cmp++; if (mem_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL held_rdata_%0d: got %h want deadbeef", i, mem_rdata); end
            n_cmp++; if (dmem_read !== 1'b0) begin n_err++; $display("FAIL held_rereq_%0d: got %b want 0", i, dmem_read); end
            n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL held_stall_%0d: got %b want 0", i, mem_stall); end
            next_cycle();
        end
        set_op(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0);
        dmem_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        n_cmp++; if (mem_rdata !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL held_released: got %h want 5a5a5a5a", mem_rdata); end
        next_cycle();
        // Late response while held: BUSY -> DONE.
        set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0204, 32'h0);
        dmem_resp = 1'b0; advance = 1'b0; dmem_rdata = 32'h0;
        next_cycle();
        dmem_resp = 1'b1; dmem_rdata = 32'h0BAD_F00D;
        next_cycle();
        dmem_resp = 1'b0; dmem_rdata = 32'h0;
        @(negedge clk);
        n_cmp++; if (mem_rdata !== 32'h0BAD_F00D) begin n_err++; $display("FAIL busy_held_rdata: got %h want 0badf00d", mem_rdata); end
        n_cmp++; if (dmem_read !== 1'b0) begin n_err++; $display("FAIL busy_held_rereq: got %b want 0", dmem_read); end
        advance = 1'b1;
        next_cycle();
        set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        next_cycle();
    endtask

    task automatic test_back_to_back();
        dmem_resp = 1'b1; advance = 1'b1;
        set_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344);
        @(negedge clk);
        n_cmp++; if ({dmem_write, dmem_read, mem_stall} !== 3'b100) begin n_err++; $display("FAIL b2b_sw_ctl: got %b want 100", {dmem_write, dmem_read, mem_stall}); end
        n_cmp++; if (dmem_wdata !== 32'h1122_3344) begin n_err++; $display("FAIL b2b_sw_wdata: got %h want 11223344", dmem_wdata); end
        next_cycle();
        set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0014, 32'h0);
        dmem_rdata = 32'h5566_7788;
        @(negedge clk);
        n_cmp++; if ({dmem_write, dmem_read, mem_stall} !== 3'b010) begin n_err++; $display("FAIL b2b_lw_ctl: got %b want 010", {dmem_write, dmem_read, mem_stall}); end
        n_cmp++; if (mem_rdata !== 32'h5566_7788) begin n_err++; $display("FAIL b2b_lw_rdata: got %h want 55667788", mem_rdata); end
        next_cycle();
        set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        dmem_resp = 1'b0;
        @(negedge clk);
        n_cmp++; if ({dmem_write, dmem_read, mem_stall} !== 3'b000) begin n_err++; $display("FAIL b2b_after: got %b want 000", {dmem_write, dmem_read, mem_stall}); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
        dmem_resp = 1'b0; advance = 1'b0;
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (dmem_read !== 1'b0) begin n_err++; $display("FAIL rstmid_dmem_read: got %b want 0", dmem_read); end
        n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL rstmid_stall: got %b want 0", mem_stall); end
        next_cycle();
        // With valid low, only a lingering BUSY state would keep the request up.
        rst = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (dmem_read !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got %b want 0", dmem_read); end
        next_cycle();
        valid = 1'b1; dmem_resp = 1'b1; advance = 1'b1; dmem_rdata = 32'h7777_0001;
        @(negedge clk);
        n_cmp++; if ({dmem_read, mem_stall} !== 2'b10) begin n_err++; $display("FAIL rstmid_next_lw: got %b want 10", {dmem_read, mem_stall}); end
        n_cmp++; if (mem_rdata !== 32'h7777_0001) begin n_err++; $display("FAIL rstmid_next_rdata: got %h want 77770001", mem_rdata); end
        next_cycle();
        set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        dmem_resp = 1'b0;
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        advance = 1'b0; dmem_resp = 1'b0; dmem_rdata = 32'h0;
        next_cycle();
        test_reset();
        test_load_word();
        test_store_byte();
        test_misaligned();
        test_resp_held();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RV32I pipeline, between the EX/MEM stage register and the MEM/WB stage register. Forms byte/half/word load and store requests for the data memory port and holds the request until the memory responds. Stalls the pipeline while a request is outstanding, and captures read data if the response arrives while the pipeline is held by another stage. Produces the raw read word, byte offset, masks, shifted store data, stall flag and misalignment trap that the MEM/WB register latches.

## Interface
- No parameters.
- Reset is synchronous and active-high. There is one clock, `clk`; the reset port is `rst`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `valid`  in  1  EX/MEM holds a live instruction.
- `mem_read`  in  1  instruction is a load.
- `mem_write`  in  1  instruction is a store.
- `funct3`  in  3  access width and sign (000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned).
- `alu_res`  in  32  effective address.
- `rs2_data`  in  32  store source.
- `advance`  in  1  MEM/WB load this cycle (global pipeline advance).
- `dmem_address`  out  32  `{alu_res[31:2], 2'b00}`.
- `dmem_read`  out  1  read request.
- `dmem_write`  out  1  write request.
- `dmem_wmask`  out  4  byte write enables.
- `dmem_wdata`  out  32  shifted store data.
- `dmem_rdata`  in  32  read word.
- `dmem_resp`  in  1  request complete; one-cycle pulse.
- `mem_rdata`  out  32  raw aligned read word to MEM/WB.
- `bit_shift`  out  2  `alu_res[1:0]`.
- `wmask_out`  out  4  store mask to MEM/WB.
- `rmask_out`  out  4  load mask to MEM/WB.
- `write_data`  out  32  equals `dmem_wdata`.
- `trap`  out  1  misaligned access.
- `mem_stall`  out  1  hold all upstream stage registers and MEM/WB.

## Operation
- `op` is defined as `valid & (mem_read | mem_write) & !trap`.
- **Base mask:**
  - funct3[1:0]=00 gives 4'b0001.
  - 01 gives 4'b0011.
  - 10 gives 4'b1111.
  - 11 is treated as 4'b0000, with no trap.
- The mask sent is the base mask << `alu_res[1:0]`, truncated to 4 bits.
- **Trap:** asserted when `valid & (mem_read|mem_write)` and either:
  - half access with `alu_res[0]`=1, or
  - word access with `alu_res[1:0]`≠0.
  - When `trap` is high, no memory request is made and both masks are 0.
- `rmask_out` is the mask when `mem_read`, else 0. `wmask_out` and `dmem_wmask` are the mask when `mem_write`, else 0.
- `write_data` is `rs2_data << (8*alu_res[1:0])`.
- **States:** IDLE, BUSY, DONE.
  - IDLE:
    - `op` & `dmem_resp` & !`advance` → DONE.
    - `op` & !`dmem_resp` → BUSY.
    - Otherwise stay in IDLE.
  - BUSY:
    - `dmem_resp` & `advance` → IDLE.
    - `dmem_resp` & !`advance` → DONE.
    - Otherwise stay in BUSY.
  - DONE: `advance` → IDLE; otherwise stay in DONE.
- **Requests:**
  - `dmem_read` = `mem_read & ((IDLE & op) | BUSY)`.
  - `dmem_write` is formed the same way with `mem_write`.
  - The request is held until the `dmem_resp` cycle.
  - No request is made in DONE, so the operation is never reissued.
- **Stall:** `mem_stall` = `((IDLE & op) | BUSY) & !dmem_resp`.
- **Read data:** on any response in which the next state is DONE, `dmem_rdata` is captured into a 32-bit holding register. `mem_rdata` is the holding register in DONE and `dmem_rdata` otherwise.
- Inputs are stable while `mem_stall` or DONE holds, because upstream registers do not load.
- **Reset:**
  - State goes to IDLE and the holding register is cleared to 0.
  - While `rst` is high, `dmem_read`, `dmem_write` and `mem_stall` are forced to 0.
  - An outstanding request is abandoned; the memory side is reset on the same `rst`.
  - All combinational outputs follow their inputs otherwise, with the reset-cycle values being address/data derived from the inputs.

## Timing
- Zero-wait memory (resp in the request cycle): no stall cycle; MEM/WB captures on the same edge.
- N-cycle memory: `mem_stall` is high for exactly N cycles after the request cycle, deasserting in the resp cycle.
- Response while `advance`=0 (another stage stalling): go to DONE. `mem_rdata` stays constant from the capture until `advance`.
- A new instruction arriving in IDLE the cycle after `advance` issues its request that same cycle; there is no bubble.
- A trapping or non-memory instruction never stalls and never leaves IDLE.

## Test plan
- **Aligned word load:** lw at 0x100 with a 2-cycle memory. Required: dmem_read high for 3 cycles, mem_stall high for 2, rmask 1111, mem_rdata = dmem_rdata on the resp edge.
- **Store byte:** sb at 0x103 with rs2=0x000000AB. Required: dmem_address 0x100, wmask 1000, wdata 0xAB000000, rmask 0000.
- **Misaligned access:** lh at 0x101, and separately lw at 0x102. Required: trap=1, no dmem_read, mem_stall=0, both masks 0000.
- **Response while held:** resp with rdata 0xDEADBEEF while advance=0 for 3 cycles, then memory drives 0. Required: state DONE, no re-request, mem_rdata stays 0xDEADBEEF until advance.
- **Back-to-back zero-wait:** sw followed by lw. Required: mem_stall never asserts, one request per instruction.
- **Reset mid-request:** rst asserted while in BUSY. Required: dmem_read=0 during rst, state IDLE after, holding register 0; the next lw issues normally.
